// File: rtl/riscv_alu_arb.sv
// riscv_alu_arb: two-port arbiter/sequencer in front of the shared riscv_alu.
// Each accepted operation runs IDLE -> EXEC -> RESP, so the ALU sees registered
// operands for a full cycle and the result returns with a one-cycle valid.
// Optional macro RISCV_ALU_ARB_FIXPRI_EN: fixed priority (port 0 wins) instead
// of round-robin; the Last register is then not built.
module riscv_alu_arb #(
    parameter int DW = 32
) (
    input  logic          Clk_i,
    input  logic          Rst_n_i,
    input  logic          Req0_i,
    input  logic [3:0]    Ctl0_i,
    input  logic [DW-1:0] A0_i,
    input  logic [DW-1:0] B0_i,
    output logic          Gnt0_o,
    output logic          Vld0_o,
    input  logic          Req1_i,
    input  logic [3:0]    Ctl1_i,
    input  logic [DW-1:0] A1_i,
    input  logic [DW-1:0] B1_i,
    output logic          Gnt1_o,
    output logic          Vld1_o,
    output logic [DW-1:0] Result_o,
    output logic          Busy_o,
    output logic [3:0]    AluCtl_o,
    output logic [DW-1:0] AluA_o,
    output logic [DW-1:0] AluB_o,
    input  logic [DW-1:0] AluOut_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q;
    logic          owner_q;
    logic          vld0_q;
    logic          vld1_q;
    logic          busy_q;
    logic [3:0]    ctl_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] result_q;
`ifndef RISCV_ALU_ARB_FIXPRI_EN
    logic          last_q;
`endif

    logic          any_req_d;
    logic          win1_d;
    logic          grant_d;

    // Pick the winner among live requests; a grant only exists in IDLE and out of reset
    always_comb begin
        any_req_d = Req0_i | Req1_i;
`ifdef RISCV_ALU_ARB_FIXPRI_EN
        win1_d    = Req1_i & ~Req0_i;
`else
        // Under contention the port that was not granted last time wins
        win1_d    = Req1_i & (~Req0_i | ~last_q);
`endif
        grant_d   = Rst_n_i & (state_q == IDLE) & any_req_d;
    end

    assign Gnt0_o   = grant_d & ~win1_d;
    assign Gnt1_o   = grant_d & win1_d;
    assign Vld0_o   = vld0_q;
    assign Vld1_o   = vld1_q;
    assign Busy_o   = busy_q;
    assign Result_o = result_q;
    assign AluCtl_o = ctl_q;
    assign AluA_o   = a_q;
    assign AluB_o   = b_q;

    // Sequencer: capture winner operands, let the ALU evaluate, return the result
    always_ff @(posedge Clk_i) begin
        if (!Rst_n_i) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            vld0_q   <= 1'b0;
            vld1_q   <= 1'b0;
            busy_q   <= 1'b0;
            ctl_q    <= 4'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
`ifndef RISCV_ALU_ARB_FIXPRI_EN
            last_q   <= 1'b1;
`endif
        end else begin
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        ctl_q   <= win1_d ? Ctl1_i : Ctl0_i;
                        a_q     <= win1_d ? A1_i : A0_i;
                        b_q     <= win1_d ? B1_i : B0_i;
                        owner_q <= win1_d;
`ifndef RISCV_ALU_ARB_FIXPRI_EN
                        last_q  <= win1_d;
`endif
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Valid is registered here so it is high exactly during RESP
                    result_q <= AluOut_i;
                    vld0_q   <= ~owner_q;
                    vld1_q   <= owner_q;
                    state_q  <= RESP;
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_alu_arb.sv
// Bench for riscv_alu_arb: directed scenarios with literal results plus a
// randomized phase, all checked every cycle against a timeline model.
module tb_riscv_alu_arb;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_SLL  = 4'd5;
    localparam logic [3:0] ALUOP_SRL  = 4'd6;
    localparam logic [3:0] ALUOP_SRA  = 4'd7;
    localparam logic [3:0] ALUOP_SLT  = 4'd8;
    localparam logic [3:0] ALUOP_SLTU = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  ctl0 = 4'd0, ctl1 = 4'd0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
    logic        gnt0, gnt1, vld0, vld1, busy;
    logic [31:0] result, alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctl;

    int tests = 0;
    int fails = 0;

    // Behavioural stand-in for the shared ALU
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALUOP_ADD:  return a + b;
            ALUOP_SUB:  return a - b;
            ALUOP_AND:  return a & b;
            ALUOP_OR:   return a | b;
            ALUOP_XOR:  return a ^ b;
            ALUOP_SLL:  return a << b[4:0];
            ALUOP_SRL:  return a >> b[4:0];
            ALUOP_SRA:  return $signed(a) >>> b[4:0];
            ALUOP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALUOP_SLTU: return {31'd0, a < b};
            default:    return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_f(alu_ctl, alu_a, alu_b);

    riscv_alu_arb #(.DW(32)) dut (
        .Clk_i(clk), .Rst_n_i(rst_n),
        .Req0_i(req0), .Ctl0_i(ctl0), .A0_i(a0), .B0_i(b0), .Gnt0_o(gnt0), .Vld0_o(vld0),
        .Req1_i(req1), .Ctl1_i(ctl1), .A1_i(a1), .B1_i(b1), .Gnt1_o(gnt1), .Vld1_o(vld1),
        .Result_o(result), .Busy_o(busy),
        .AluCtl_o(alu_ctl), .AluA_o(alu_a), .AluB_o(alu_b), .AluOut_i(alu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // An accepted op at cycle n occupies the ALU until n+3 and reports at n+2.
    int          cyc = 0;
    bit          armed = 0;
    int          free_cyc = 0;
    bit          pend_v = 0;
    bit          pend_own = 0;
    int          pend_due = 0;
    logic [31:0] pend_val = 0;
    bit          last = 1;
    logic [31:0] e_res = 0, e_a = 0, e_b = 0;
    logic [3:0]  e_ctl = 0;

    always @(negedge clk) begin
        bit ev0, ev1, ebusy, eg, win;
        ev0 = 0; ev1 = 0; eg = 0; win = 0;
        if (armed) begin
            if (pend_v && pend_due == cyc) begin
                ev0 = !pend_own;
                ev1 = pend_own;
                e_res = pend_val;
                pend_v = 0;
            end
            ebusy = (cyc < free_cyc);
            if (rst_n && !ebusy && (req0 || req1)) begin
                eg = 1;
`ifdef RISCV_ALU_ARB_FIXPRI_EN
                win = !req0;
`else
                win = (req0 && req1) ? !last : req1;
`endif
            end
            chk("m_gnt0", 32'(gnt0), 32'(eg && !win));
            chk("m_gnt1", 32'(gnt1), 32'(eg && win));
            chk("m_vld0", 32'(vld0), 32'(ev0));
            chk("m_vld1", 32'(vld1), 32'(ev1));
            chk("m_busy", 32'(busy), 32'(ebusy));
            chk("m_result", result, e_res);
            chk("m_aluctl", 32'(alu_ctl), 32'(e_ctl));
            chk("m_alua", alu_a, e_a);
            chk("m_alub", alu_b, e_b);
        end
        if (!rst_n) begin
            armed = 1; free_cyc = cyc + 1; pend_v = 0; last = 1;
            e_res = 0; e_ctl = 0; e_a = 0; e_b = 0;
        end else if (eg) begin
            e_ctl = win ? ctl1 : ctl0;
            e_a   = win ? a1 : a0;
            e_b   = win ? b1 : b0;
            pend_v = 1; pend_own = win; pend_due = cyc + 2;
            pend_val = alu_f(e_ctl, e_a, e_b);
            free_cyc = cyc + 3;
            last = win;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_op(input bit p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (p) begin req1 = 1; ctl1 = c; a1 = a; b1 = b; end
        else   begin req0 = 1; ctl0 = c; a0 = a; b0 = b; end
    endtask

    task automatic wait_gnt(input bit p, input string name);
        int n = 0;
        @(negedge clk);
        while (!(p ? gnt1 : gnt0) && n < 20) begin n++; @(negedge clk); end
        chk(name, 32'(p ? gnt1 : gnt0), 32'd1);
    endtask

    // One complete operation on port p with a hand-computed expected result
    task automatic run_op(input bit p, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        set_op(p, c, a, b);
        wait_gnt(p, {name, "_gnt"});
        chk({name, "_busy_g"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        if (p) req1 = 0; else req0 = 0;
        @(negedge clk);
        chk({name, "_busy_x"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({name, "_busy_r"}, 32'(busy), 32'd1);
        chk({name, "_vld"}, 32'(p ? vld1 : vld0), 32'd1);
        chk({name, "_vld_other"}, 32'(p ? vld0 : vld1), 32'd0);
        chk({name, "_res"}, result, exp);
        @(negedge clk);
        chk({name, "_busy_i"}, 32'(busy), 32'd0);
        chk({name, "_vld_end"}, 32'(p ? vld1 : vld0), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        bit g0, g1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_vld", 32'({vld1, vld0}), 32'd0);

        run_op(0, ALUOP_ADD, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, "add");
        run_op(1, ALUOP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");

        // Contention: both held from reset
        @(posedge clk); #1;
        rst_n = 0;
        set_op(0, ALUOP_OR, 32'hF0, 32'h0F);
        set_op(1, ALUOP_OR, 32'h1, 32'h2);
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            logic [31:0] ew, er;
`ifdef RISCV_ALU_ARB_FIXPRI_EN
            ew = 32'd0; er = 32'hFF;
`else
            ew = 32'(k % 2); er = (k % 2 == 1) ? 32'h3 : 32'hFF;
`endif
            @(negedge clk);
            while (!(gnt0 || gnt1) && n < 20) begin n++; @(negedge clk); end
            chk("cont_any_gnt", 32'(gnt0 | gnt1), 32'd1);
            chk("cont_order", 32'(gnt1), ew);
            @(negedge clk);
            @(negedge clk);
            chk("cont_res", result, er);
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;

        // Port 1 arrives while port 0 is in EXEC
        @(posedge clk); #1;
        set_op(0, ALUOP_SUB, 32'd10, 32'd3);
        wait_gnt(0, "busy_gnt0");
        @(posedge clk); #1;
        req0 = 0;
        set_op(1, ALUOP_ADD, 32'd3, 32'd4);
        @(negedge clk);
        chk("busy_gnt1_exec", 32'(gnt1), 32'd0);
        chk("busy_alua_exec", alu_a, 32'd10);
        @(negedge clk);
        chk("busy_gnt1_resp", 32'(gnt1), 32'd0);
        chk("busy_vld0", 32'(vld0), 32'd1);
        chk("busy_res0", result, 32'd7);
        @(negedge clk);
        chk("busy_gnt1_idle", 32'(gnt1), 32'd1);
        @(posedge clk); #1;
        req1 = 0;
        @(negedge clk);
        chk("busy_alua1", alu_a, 32'd3);
        @(negedge clk);
        chk("busy_vld1", 32'(vld1), 32'd1);
        chk("busy_res1", result, 32'd7);

        // Reset during EXEC discards the op
        @(posedge clk); #1;
        set_op(0, ALUOP_XOR, 32'hFFFF, 32'h00FF);
        wait_gnt(0, "mid_gnt");
        @(posedge clk); #1;
        req0 = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_result", result, 32'd0);
        chk("mid_vld", 32'({vld1, vld0}), 32'd0);
        @(posedge clk); #1;
        set_op(0, ALUOP_ADD, 32'd1, 32'd1);
        set_op(1, ALUOP_ADD, 32'd2, 32'd2);
        @(negedge clk);
        chk("mid_first_gnt0", 32'(gnt0), 32'd1);
        chk("mid_first_gnt1", 32'(gnt1), 32'd0);
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        repeat (3) @(posedge clk);

        run_op(0, 4'hF, 32'h1234, 32'h1, 32'h0, "illegal");

        // Randomized traffic obeying the requester rules
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            g0 = gnt0; g1 = gnt1;
            @(posedge clk); #1;
            if (req0 && g0) begin
                if ($urandom_range(0, 1) == 1) set_op(0, 4'($urandom_range(0, 15)), $urandom, $urandom);
                else req0 = 0;
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                set_op(0, 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            if (req1 && g1) begin
                if ($urandom_range(0, 1) == 1) set_op(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
                else req1 = 0;
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                set_op(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            rst_n = ($urandom_range(0, 60) != 0);
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0; rst_n = 1;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_alu_arb.md
Name: riscv_alu_arb

Overview:
- Two-requester arbiter and sequencer for the single shared riscv_alu instance.
- Accepts requests carrying an ALU control code and two operands, and grants one requester at a time.
- Drives the ALU from registered operands, captures the ALU result, and returns it with a one-cycle valid pulse to the granted requester.
- Sits between the integer-issue requester (port 0) and the address-generation requester (port 1) and the shared ALU.

Parameters:
- DW, 32, operand/result width; must equal `dw from define.h.

Ports:
- Clk_i  input  1  clock; all state updates on the rising edge.
- Rst_n_i  input  1  reset; synchronous, active-low.
- Req0_i  input  1  port 0 request; held until the grant is seen.
- Ctl0_i  input  4  port 0 ALU control code (`aluop_*).
- A0_i  input  DW  port 0 operand A.
- B0_i  input  DW  port 0 operand B.
- Gnt0_o  output  1  port 0 grant; operands are captured on this cycle's edge.
- Vld0_o  output  1  port 0 result valid, one-cycle pulse.
- Req1_i, Ctl1_i, A1_i, B1_i, Gnt1_o, Vld1_o: same as port 0, for port 1.
- Result_o  output  DW  registered ALU result; meaningful when Vld0_o or Vld1_o is high.
- Busy_o  output  1  high when state is not IDLE.
- AluCtl_o  output  4  to ALU AluCtl_i.
- AluA_o  output  DW  to ALU A_i.
- AluB_o  output  DW  to ALU B_i.
- AluOut_i  input  DW  from ALU AluOut_o.

Behaviour:
- FSM states:
  - IDLE: accepts a request.
  - EXEC: the ALU evaluates the registered operands.
  - RESP: the result is presented to the owner.
- IDLE, arbitration:
  - If any Req is high, exactly one Gnt is driven high combinationally (Gntx = IDLE & selected).
  - At the edge: capture Ctl/A/B of the winner into AluCtl_o/AluA_o/AluB_o, record Owner, go to EXEC.
  - No request: stay IDLE, Gnt low.
- Round-robin: a 1-bit Last register holds the last granted port.
  - Both requesting: grant the port != Last.
  - One requesting: grant it.
  - Last updates at the grant edge.
- EXEC: one cycle. At the edge, Result_o <= AluOut_i, go to RESP.
- RESP: Vld[Owner]_o = 1 for exactly one cycle; the other Vld stays 0. At the edge, go to IDLE.
- Latency: grant edge T, result valid during cycle T+2. Throughput is one operation per 3 cycles. No grant in EXEC/RESP, even if requests are pending.
- Requester rules:
  - Hold Req and operands stable until the cycle Gnt is high.
  - Deassert Req the cycle after the grant unless issuing a new operation.
  - A Req held continuously is treated as back-to-back operations; the next grant is possible in the IDLE cycle following RESP.
  - Req dropped before its grant: no operation, no state change.
- AluCtl_o/AluA_o/AluB_o hold the last captured values outside a grant edge; the ALU is never driven from live request inputs.
- Result_o holds its value after RESP until the next EXEC edge.
- Unknown Ctl codes are passed through unchanged; the ALU's default result (zero) is returned with a normal Vld pulse.
- Reset values (Rst_n_i low at an edge, any state, including mid EXEC/RESP):
  - State IDLE; Last=1, so port 0 wins the first simultaneous request.
  - Owner=0, Result_o=0, AluCtl_o=4'b0, AluA_o=0, AluB_o=0.
  - Vld0_o=Vld1_o=0, Gnt0_o=Gnt1_o=0, Busy_o=0.
  - An in-flight operation is discarded; no Vld is issued for it.
- Gnt outputs are forced low while Rst_n_i is low.

Optional Feature:
- Macro: RISCV_ALU_ARB_FIXPRI_EN.
- Defined: fixed priority, port 0 always wins when both ports request. The Last register and its update logic are removed.
- Undefined: round-robin as described above.

Test Plan:
- Single op: reset, then Req0=1, Ctl0=`aluop_add, A0=32'h0000_0005, B0=32'h0000_0007 -> Gnt0 high in the first IDLE cycle; two cycles after the grant edge, Vld0=1 for one cycle, Result_o=32'h0000_000C; Vld1 stays 0.
- SRA via port 1: Req1, Ctl1=`aluop_sra, A1=32'h8000_0000, B1=32'd4 -> Vld1 pulse with Result_o=32'hF800_0000; Busy_o high for exactly 2 cycles.
- Contention:
  - Without the macro: Req0 and Req1 held high from reset with `aluop_or operands 32'hF0/32'h0F and 32'h1/32'h2 -> grants alternate 0,1,0,1; results 32'hFF, 32'h3, 32'hFF, 32'h3.
  - With RISCV_ALU_ARB_FIXPRI_EN: only port 0 is granted while both requests are held.
- Request during busy: Req1 rises in the EXEC cycle of a port 0 operation -> Gnt1 stays low until the IDLE cycle after Vld0; port 1 operands are captured then.
- Reset mid-operation: Rst_n_i low during the EXEC cycle -> no Vld pulse; Result_o=0 and Busy_o=0 after the edge. The next Req0 and Req1 together grant port 0 first.
- Illegal control code: Ctl0=4'hF, A0=32'h1234, B0=32'h1 -> Vld0 pulse with Result_o=32'h0.
